pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the payload carried through the stage.
REQ-002 Parameter PULSE_W, default 2, width of one-shot control bits, e.g. cache enable/write, issued once per entry.
REQ-003 Parameter RST_DATA, default 0, value loaded into payload registers on reset.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-low (asserted when 0).
REQ-006 flush  in  1  synchronous kill of all entries held in the stage.
REQ-007 in_valid  in  1  upstream presents an entry.
REQ-008 in_ready  out  1  stage accepts an entry this cycle.
REQ-009 in_data  in  DATA_W  upstream payload.
REQ-010 in_pulse  in  PULSE_W  upstream one-shot control bits.
REQ-011 out_valid  out  1  stage presents an entry downstream.
REQ-012 out_ready  in  1  downstream consumes the presented entry.
REQ-013 out_data  out  DATA_W  presented payload.
REQ-014 out_pulse  out  PULSE_W  one-shot bits, nonzero only in the first cycle an entry is presented.
REQ-015 occupancy  out  2  number of entries held: 0, 1, or 2 (2 only with skid buffer).

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-017 Latency SHALL be 1 cycle: an entry accepted at edge N SHALL be presented on out_* after edge N when the output register is free.
REQ-018 While out_valid && !out_ready, out_data SHALL hold its value and entry order SHALL be preserved (FIFO).
REQ-019 out_pulse SHALL equal the entry's in_pulse in the first cycle the entry is presented, and SHALL be 0 in every later stall cycle for that entry.
REQ-020 out_pulse SHALL be 0 whenever out_valid is 0.
REQ-021 Simultaneous input and output transfer on a stage holding one entry SHALL replace that entry, keep occupancy unchanged, and re-arm out_pulse for the new entry.
REQ-022 flush SHALL, at the next edge, clear out_valid, all held entries, out_pulse, and occupancy to 0; payload registers MAY keep stale values.
REQ-023 flush together with an input transfer in the same cycle SHALL discard the incoming entry; flush wins.
REQ-024 occupancy SHALL increment on input-only transfer, decrement on output-only transfer, and stay unchanged on both or neither.
REQ-025 in_valid, in_data, and in_pulse SHALL be ignored when in_ready is 0.

Reset
REQ-026 While rst=0: out_valid=0, out_pulse=0, occupancy=0, out_data=RST_DATA, skid entry empty; applied immediately, independent of clk.
REQ-027 Reset mid-stall SHALL drop all held entries; the first cycle after release SHALL behave as an empty stage.
REQ-028 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-029 Macro PIPE_SKID_EN defined: a 2-entry skid buffer is built; in_ready SHALL be a registered signal equal to !(skid entry full), with no combinational path from out_ready; occupancy reaches 2.
REQ-030 PIPE_SKID_EN undefined: single register; in_ready = !out_valid || out_ready (combinational); occupancy never exceeds 1.

Verification
REQ-031 Streaming: in_valid=1, out_ready=1, in_data 1,2,3 on consecutive cycles, in_pulse=2'b11 -> out_data 1,2,3 one cycle later; out_pulse=2'b11 each cycle; occupancy=1.
REQ-032 Stall: entry 0xA5 with in_pulse=2'b01, then out_ready=0 for 3 cycles -> out_data=0xA5 for all 4 cycles; out_pulse=01 only in the first cycle, 00 after.
REQ-033 Skid (PIPE_SKID_EN): out_ready=0, push 0x10 then 0x20 -> occupancy=2, in_ready=0; release out_ready -> 0x10 then 0x20 presented in order, in_ready=1 one cycle after the skid entry drains.
REQ-034 Flush: occupancy=2, flush=1 with in_valid=1 and in_data=0x33 -> next cycle out_valid=0, occupancy=0, 0x33 never presented.
REQ-035 Reset: rst pulled to 0 between edges while stalled with 0x77 -> out_valid=0 and out_data=RST_DATA before the next edge; after release, in_ready=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one-entry valid/ready pipeline register with one-shot control bits.
//
// Build option: define PIPE_SKID_EN to add a second (skid) entry. This makes
// in_ready a registered signal with no combinational path from out_ready, and
// lets occupancy reach 2. With the macro undefined, the stage is a single
// register and in_ready = !out_valid || out_ready.
//
// out_pulse carries the entry's one-shot bits (for example a cache enable or
// write strobe) only in the first cycle that entry is presented. It is zero
// during later stall cycles and whenever out_valid is low.

module pipe_stage_reg #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       PULSE_W  = 2,
   parameter logic [DATA_W-1:0] RST_DATA = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [PULSE_W-1:0] in_pulse,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [PULSE_W-1:0] out_pulse,
   output logic [1:0]         occupancy
);

   logic               main_valid_q, main_valid_d;
   logic [DATA_W-1:0]  main_data_q,  main_data_d;
   logic [PULSE_W-1:0] main_pulse_q, main_pulse_d;
   logic [1:0]         occ_q,        occ_d;

   logic               in_fire;
   logic               out_fire;

   // Transfer qualifiers shared by both build variants
   always_comb begin
      in_fire  = in_valid && in_ready;
      out_fire = main_valid_q && out_ready;
   end

`ifdef PIPE_SKID_EN

   logic               skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0]  skid_data_q,  skid_data_d;
   logic [PULSE_W-1:0] skid_pulse_q, skid_pulse_d;
   logic               in_ready_q,   in_ready_d;

   // Next state for the main and skid entries; the skid only fills while main is held
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_pulse_d = '0;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_pulse_d = skid_pulse_q;
      occ_d        = occ_q;

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         occ_d        = 2'd0;
      end else begin
         // Drain: the skid entry moves up, or the main entry empties
         if (out_fire) begin
            if (skid_valid_q) begin
               main_valid_d = 1'b1;
               main_data_d  = skid_data_q;
               main_pulse_d = skid_pulse_q;
               skid_valid_d = 1'b0;
            end else begin
               main_valid_d = 1'b0;
            end
         end
         // Fill: an entry goes to main when main is (or is becoming) free, else to the skid.
         // in_ready is low whenever the skid is full, so the skid is never overwritten.
         if (in_fire) begin
            if (!main_valid_q || (out_fire && !skid_valid_q)) begin
               main_valid_d = 1'b1;
               main_data_d  = in_data;
               main_pulse_d = in_pulse;
            end else begin
               skid_valid_d = 1'b1;
               skid_data_d  = in_data;
               skid_pulse_d = in_pulse;
            end
         end
         case ({in_fire, out_fire})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
         endcase
      end

      in_ready_d = !skid_valid_d;
   end

   // Skid entry and registered ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skid_valid_q <= 1'b0;
         skid_data_q  <= RST_DATA;
         skid_pulse_q <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_pulse_q <= skid_pulse_d;
         in_ready_q   <= in_ready_d;
      end
   end

   // Ready comes straight from a flop; out_ready never reaches it combinationally
   always_comb begin
      in_ready = in_ready_q;
   end

`else

   // Next state for the single output register
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_pulse_d = '0;
      occ_d        = occ_q;

      if (flush) begin
         main_valid_d = 1'b0;
         occ_d        = 2'd0;
      end else if (in_fire) begin
         // Covers both fill-when-empty and replace-on-drain; the pulse re-arms either way
         main_valid_d = 1'b1;
         main_data_d  = in_data;
         main_pulse_d = in_pulse;
         occ_d        = 2'd1;
      end else if (out_fire) begin
         main_valid_d = 1'b0;
         occ_d        = 2'd0;
      end
   end

   // Accept when empty or when the held entry leaves this cycle
   always_comb begin
      in_ready = !main_valid_q || out_ready;
   end

`endif

   // Main output register and occupancy count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_valid_q <= 1'b0;
         main_data_q  <= RST_DATA;
         main_pulse_q <= '0;
         occ_q        <= 2'd0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_pulse_q <= main_pulse_d;
         occ_q        <= occ_d;
      end
   end

   // Output drive; the pulse is masked by valid as a guard even though it is cleared with it
   always_comb begin
      out_valid = main_valid_q;
      out_data  = main_data_q;
      out_pulse = main_pulse_q & {PULSE_W{main_valid_q}};
      occupancy = occ_q;
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic, checked against a queue model.
// Build with PIPE_SKID_EN defined to exercise the skid-buffer variant.

module tb_pipe_stage_reg;

   localparam logic [31:0] RSTV = 32'hC0DE_0001;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [1:0]  in_pulse;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_pulse;
   logic [1:0]  occupancy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  p;
   } ent_t;

   ent_t q[$];
   bit   fresh = 1'b0;

   pipe_stage_reg #(.DATA_W(32), .PULSE_W(2), .RST_DATA(RSTV)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pulse(in_pulse),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pulse(out_pulse),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_ready(input bit ordy);
`ifdef PIPE_SKID_EN
      return q.size() < 2;
`else
      return (q.size() == 0) || ordy;
`endif
   endfunction

   // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
   task automatic cyc(input bit v, input logic [31:0] d, input logic [1:0] p,
                      input bit ordy, input bit fl, input string tag);
      bit   ir, inf, outf, empty_before;
      ent_t e;
      in_valid  = v;
      in_data   = d;
      in_pulse  = p;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      ir = model_ready(ordy);
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0)
         chk({tag, ".data"}, out_data, q[0].d);
      chk({tag, ".pulse"}, {30'd0, out_pulse},
          {30'd0, (q.size() > 0 && fresh) ? q[0].p : 2'b00});
      chk({tag, ".occ"}, {30'd0, occupancy}, q.size());
      chk({tag, ".rdy"}, {31'd0, in_ready}, {31'd0, ir});
      inf  = v && ir;
      outf = (q.size() > 0) && ordy;
      @(posedge clk);
      #1;
      if (fl) begin
         q.delete();
         fresh = 1'b0;
      end else begin
         empty_before = (q.size() == 0);
         if (outf) void'(q.pop_front());
         if (inf) begin
            e.d = d;
            e.p = p;
            q.push_back(e);
         end
         fresh = (q.size() > 0) && (outf || empty_before);
      end
   endtask

   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_pulse  = '0;
      out_ready = 1'b0;

      // Reset state while reset is held
      repeat (2) @(posedge clk);
      #1;
      chk("rst.valid", {31'd0, out_valid}, 32'd0);
      chk("rst.data", out_data, RSTV);
      chk("rst.pulse", {30'd0, out_pulse}, 32'd0);
      chk("rst.occ", {30'd0, occupancy}, 32'd0);
      rst = 1'b1;
      chk("rel.rdy", {31'd0, in_ready}, 32'd1);

      // Streaming 1,2,3 with pulse 11
      cyc(1, 32'd1, 2'b11, 1, 0, "str0");
      cyc(1, 32'd2, 2'b11, 1, 0, "str1");
      cyc(1, 32'd3, 2'b11, 1, 0, "str2");
      cyc(0, 32'd0, 2'b00, 1, 0, "str3");
      cyc(0, 32'd0, 2'b00, 1, 0, "str4");

      // Stall: A5 held for four cycles, pulse only in the first
      cyc(1, 32'hA5, 2'b01, 0, 0, "stl0");
      cyc(0, 32'h0, 2'b00, 0, 0, "stl1");
      cyc(0, 32'h0, 2'b00, 0, 0, "stl2");
      cyc(0, 32'h0, 2'b00, 0, 0, "stl3");
      cyc(1, 32'hEE, 2'b10, 0, 0, "stl4");
      cyc(0, 32'h0, 2'b00, 1, 0, "stl5");
      cyc(0, 32'h0, 2'b00, 1, 0, "stl6");
      cyc(0, 32'h0, 2'b00, 1, 0, "stl7");

      // Replace on simultaneous in/out: pulse re-arms for the new entry
      cyc(1, 32'h51, 2'b10, 1, 0, "rep0");
      cyc(1, 32'h52, 2'b01, 1, 0, "rep1");
      cyc(0, 32'h0, 2'b00, 1, 0, "rep2");

`ifdef PIPE_SKID_EN
      // Skid fill then ordered drain
      cyc(1, 32'h10, 2'b01, 0, 0, "skd0");
      cyc(1, 32'h20, 2'b10, 0, 0, "skd1");
      cyc(1, 32'h99, 2'b11, 0, 0, "skd2");
      chk("skd.occ2", {30'd0, occupancy}, 32'd2);
      chk("skd.rdy0", {31'd0, in_ready}, 32'd0);
      cyc(0, 32'h0, 2'b00, 1, 0, "skd3");
      cyc(0, 32'h0, 2'b00, 1, 0, "skd4");
      cyc(0, 32'h0, 2'b00, 1, 0, "skd5");
`endif

      // Flush with a full stage and a colliding input
      cyc(1, 32'h44, 2'b01, 0, 0, "fl0");
      cyc(1, 32'h45, 2'b01, 0, 0, "fl1");
      cyc(1, 32'h33, 2'b11, 0, 1, "fl2");
      cyc(0, 32'h0, 2'b00, 1, 0, "fl3");
      chk("fl.occ0", {30'd0, occupancy}, 32'd0);
      cyc(0, 32'h0, 2'b00, 1, 0, "fl4");

      // Async reset mid-stall
      cyc(1, 32'h77, 2'b01, 0, 0, "ar0");
      cyc(0, 32'h0, 2'b00, 0, 0, "ar1");
      #2;
      rst = 1'b0;
      #1;
      chk("ar.valid", {31'd0, out_valid}, 32'd0);
      chk("ar.data", out_data, RSTV);
      chk("ar.pulse", {30'd0, out_pulse}, 32'd0);
      chk("ar.occ", {30'd0, occupancy}, 32'd0);
      q.delete();
      fresh = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk("ar.rdy", {31'd0, in_ready}, 32'd1);
      cyc(0, 32'h0, 2'b00, 1, 0, "ar2");

      // Random traffic
      for (int i = 0; i < 500; i++) begin
         cyc(($urandom % 4) != 0, $urandom, 2'($urandom), ($urandom % 3) != 0,
             ($urandom % 32) == 0, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
